// File: rtl/mips_insn_encoder.sv
// Streaming MIPS-I encoder: symbolic requests in, 32-bit machine words out.
// LI expands to LUI/ORI; out-of-range immediates are dropped and counted.
module mips_insn_encoder (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [4:0]  req_kind,
   input  logic [4:0]  req_rs,
   input  logic [4:0]  req_rt,
   input  logic [4:0]  req_rd,
   input  logic [31:0] req_imm,
   output logic        ins_valid,
   input  logic        ins_ready,
   output logic [31:0] ins,
   output logic        err,
   output logic [7:0]  err_count,
   output logic [15:0] ins_count
);

   typedef enum logic {ONE, TWO} state_t;

   state_t      state;
   logic [31:0] pend;
   logic        pend_valid;
   logic [31:0] word1;
   logic [31:0] word2;
   logic        two;
   logic        legal;
   logic        accept;
   logic        sext_ok;
   logic        zext_ok;
   logic        sh_ok;
   logic        j_ok;

   localparam logic [5:0] OP_LUI = 6'b001111;
   localparam logic [5:0] OP_ORI = 6'b001101;

   function automatic logic [31:0] r_word(
      input logic [4:0] rs,
      input logic [4:0] rt,
      input logic [4:0] rd,
      input logic [4:0] sh,
      input logic [5:0] fn
   );
      return {6'b000000, rs, rt, rd, sh, fn};
   endfunction

   function automatic logic [31:0] i_word(
      input logic [5:0]  op,
      input logic [4:0]  rs,
      input logic [4:0]  rt,
      input logic [15:0] im
   );
      return {op, rs, rt, im};
   endfunction

   assign sext_ok = (&req_imm[31:15]) | ~(|req_imm[31:15]);
   assign zext_ok = ~(|req_imm[31:16]);
   assign sh_ok   = ~(|req_imm[31:5]);
   assign j_ok    = ~(|req_imm[31:26]);

   assign req_ready = !rst && (state == ONE) && (!ins_valid || ins_ready);
   assign accept    = req_valid && req_ready;

   always_comb begin
      word1 = '0;
      word2 = '0;
      two   = 1'b0;
      legal = 1'b1;
      unique case (req_kind)
         5'd0:  word1 = '0;
         5'd1:  word1 = r_word(req_rs, req_rt, req_rd, 5'd0, 6'b100000);
         5'd2:  word1 = r_word(req_rs, req_rt, req_rd, 5'd0, 6'b100010);
         5'd3:  word1 = r_word(req_rs, req_rt, req_rd, 5'd0, 6'b100100);
         5'd4:  word1 = r_word(req_rs, req_rt, req_rd, 5'd0, 6'b100101);
         5'd5:  word1 = r_word(req_rs, req_rt, req_rd, 5'd0, 6'b100110);
         5'd6: begin
            word1 = r_word(5'd0, req_rt, req_rd, req_imm[4:0], 6'b000000);
            legal = sh_ok;
         end
         5'd7: begin
            word1 = r_word(5'd0, req_rt, req_rd, req_imm[4:0], 6'b000010);
            legal = sh_ok;
         end
         5'd8: begin
            word1 = r_word(5'd0, req_rt, req_rd, req_imm[4:0], 6'b000011);
            legal = sh_ok;
         end
         5'd9:  word1 = r_word(req_rs, 5'd0, 5'd0, 5'd0, 6'b001000);
         5'd10: begin
            word1 = i_word(6'b001000, req_rs, req_rt, req_imm[15:0]);
            legal = sext_ok;
         end
         5'd11: begin
            word1 = i_word(6'b001100, req_rs, req_rt, req_imm[15:0]);
            legal = zext_ok;
         end
         5'd12: begin
            word1 = i_word(OP_ORI, req_rs, req_rt, req_imm[15:0]);
            legal = zext_ok;
         end
         5'd13: begin
            word1 = i_word(6'b001110, req_rs, req_rt, req_imm[15:0]);
            legal = zext_ok;
         end
         5'd14: begin
            word1 = i_word(6'b100011, req_rs, req_rt, req_imm[15:0]);
            legal = sext_ok;
         end
         5'd15: begin
            word1 = i_word(6'b101011, req_rs, req_rt, req_imm[15:0]);
            legal = sext_ok;
         end
         5'd16: begin
            word1 = i_word(6'b000100, req_rs, req_rt, req_imm[15:0]);
            legal = sext_ok;
         end
         5'd17: begin
            word1 = i_word(6'b000101, req_rs, req_rt, req_imm[15:0]);
            legal = sext_ok;
         end
         5'd18: begin
            word1 = i_word(OP_LUI, 5'd0, req_rt, req_imm[15:0]);
            legal = zext_ok;
         end
         5'd19: begin
            word1 = {6'b000010, req_imm[25:0]};
            legal = j_ok;
         end
         5'd20: begin
            word1 = {6'b000011, req_imm[25:0]};
            legal = j_ok;
         end
         5'd21: begin
            // Collapse to one word when either half of the value is zero
            if (req_imm[31:16] == 16'd0) begin
               word1 = i_word(OP_ORI, 5'd0, req_rt, req_imm[15:0]);
            end else if (req_imm[15:0] == 16'd0) begin
               word1 = i_word(OP_LUI, 5'd0, req_rt, req_imm[31:16]);
            end else begin
               word1 = i_word(OP_LUI, 5'd0, req_rt, req_imm[31:16]);
               word2 = i_word(OP_ORI, req_rt, req_rt, req_imm[15:0]);
               two   = 1'b1;
            end
         end
         default: legal = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ONE;
         ins        <= '0;
         ins_valid  <= 1'b0;
         pend       <= '0;
         pend_valid <= 1'b0;
         err        <= 1'b0;
         err_count  <= '0;
         ins_count  <= '0;
      end else begin
         err <= 1'b0;
         if (ins_valid && ins_ready) begin
            ins_count <= ins_count + 16'd1;
         end
         if (state == TWO) begin
            if (ins_ready && pend_valid) begin
               ins        <= pend;
               pend_valid <= 1'b0;
               state      <= ONE;
            end
         end else if (accept) begin
            if (legal) begin
               ins       <= word1;
               ins_valid <= 1'b1;
               if (two) begin
                  pend       <= word2;
                  pend_valid <= 1'b1;
                  state      <= TWO;
               end
            end else begin
               ins_valid <= 1'b0;
               err       <= 1'b1;
               if (err_count != 8'hFF) begin
                  err_count <= err_count + 8'd1;
               end
            end
         end else if (ins_valid && ins_ready) begin
            ins_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mips_insn_encoder.sv
// Directed bench for mips_insn_encoder: encodings, LI expansion,
// stalls, illegal requests and asynchronous reset.
module tb_mips_insn_encoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [4:0]  req_kind;
   logic [4:0]  req_rs;
   logic [4:0]  req_rt;
   logic [4:0]  req_rd;
   logic [31:0] req_imm;
   logic        ins_valid;
   logic        ins_ready;
   logic [31:0] ins;
   logic        err;
   logic [7:0]  err_count;
   logic [15:0] ins_count;

   int checks = 0;
   int failures = 0;

   mips_insn_encoder dut (
      .clk(clk),
      .rst(rst),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_kind(req_kind),
      .req_rs(req_rs),
      .req_rt(req_rt),
      .req_rd(req_rd),
      .req_imm(req_imm),
      .ins_valid(ins_valid),
      .ins_ready(ins_ready),
      .ins(ins),
      .err(err),
      .err_count(err_count),
      .ins_count(ins_count)
   );

   always #5 clk = ~clk;

   localparam int NV = 21;
   localparam logic [4:0] V_K [NV] = '{
      5'd10, 5'd19, 5'd20, 5'd2, 5'd9, 5'd15, 5'd14, 5'd17, 5'd18, 5'd13, 5'd10,
      5'd6, 5'd0, 5'd3, 5'd4, 5'd5, 5'd7, 5'd11, 5'd12, 5'd16, 5'd19};
   localparam logic [4:0] V_RS [NV] = '{
      5'd1, 5'd0, 5'd0, 5'd2, 5'd31, 5'd29, 5'd29, 5'd1, 5'd3, 5'd1, 5'd1,
      5'd7, 5'd5, 5'd1, 5'd1, 5'd1, 5'd0, 5'd1, 5'd1, 5'd3, 5'd0};
   localparam logic [4:0] V_RT [NV] = '{
      5'd2, 5'd0, 5'd0, 5'd3, 5'd5, 5'd31, 5'd31, 5'd0, 5'd9, 5'd2, 5'd2,
      5'd2, 5'd5, 5'd2, 5'd2, 5'd2, 5'd4, 5'd2, 5'd2, 5'd4, 5'd0};
   localparam logic [4:0] V_RD [NV] = '{
      5'd0, 5'd0, 5'd0, 5'd4, 5'd6, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0,
      5'd3, 5'd5, 5'd3, 5'd3, 5'd3, 5'd5, 5'd0, 5'd0, 5'd0, 5'd0};
   localparam logic [31:0] V_IMM [NV] = '{
      32'hFFFFFFFC, 32'h00100000, 32'h00100000, 32'h0, 32'h0,
      32'h00000004, 32'hFFFFFFF8, 32'hFFFFFFFF, 32'h0000ABCD, 32'h0000FFFF,
      32'hFFFF8000, 32'h00000004, 32'hFFFFFFFF, 32'h00000005, 32'h0,
      32'h0, 32'h00000001, 32'h00001234, 32'h000000FF, 32'h00007FFF,
      32'h03FFFFFF};
   localparam logic [31:0] V_EXP [NV] = '{
      32'h2022FFFC, 32'h08100000, 32'h0C100000, 32'h00432022, 32'h03E00008,
      32'hAFBF0004, 32'h8FBFFFF8, 32'h1420FFFF, 32'h3C09ABCD, 32'h3822FFFF,
      32'h20228000, 32'h00021900, 32'h00000000, 32'h00221824, 32'h00221825,
      32'h00221826, 32'h00042842, 32'h30221234, 32'h342200FF, 32'h10647FFF,
      32'h0BFFFFFF};

   // Waits (bounded) for req_ready, then holds the request across one edge.
   task automatic issue(
      input logic [4:0] k,
      input logic [4:0] rs,
      input logic [4:0] rt,
      input logic [4:0] rd,
      input logic [31:0] im,
      output int waited
   );
      req_kind = k;
      req_rs = rs;
      req_rt = rt;
      req_rd = rd;
      req_imm = im;
      req_valid = 1'b1;
      waited = 0;
      while (!req_ready && waited < 50) begin
         @(posedge clk); #1;
         waited++;
      end
      if (!req_ready) begin
         checks++;
         failures++;
         $display("FAIL issue_timeout req_ready=%0b want=1", req_ready);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_valid = 1'b1;
      req_kind = 5'd1;
      req_rs = '0;
      req_rt = '0;
      req_rd = '0;
      req_imm = '0;
      ins_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL rst_req_ready got=%0b want=0", req_ready); end
      checks++; if (ins_valid !== 1'b0) begin failures++; $display("FAIL rst_ins_valid got=%0b want=0", ins_valid); end
      checks++; if (ins !== 32'h0) begin failures++; $display("FAIL rst_ins got=%h want=0", ins); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_err got=%0b want=0", err); end
      checks++; if (err_count !== 8'h0) begin failures++; $display("FAIL rst_err_count got=%0d want=0", err_count); end
      checks++; if (ins_count !== 16'h0) begin failures++; $display("FAIL rst_ins_count got=%0d want=0", ins_count); end
      req_valid = 1'b0;
      rst = 1'b0;
      #1;
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL post_rst_ready got=%0b want=1", req_ready); end
   endtask

   task automatic test_back_to_back();
      int w;
      logic [15:0] c0;
      c0 = ins_count;
      ins_ready = 1'b1;
      issue(5'd1, 5'd1, 5'd2, 5'd3, 32'h0, w);
      checks++; if (ins !== 32'h00221820 || ins_valid !== 1'b1) begin failures++; $display("FAIL add_word got=%h v=%0b want=00221820", ins, ins_valid); end
      issue(5'd8, 5'd0, 5'd4, 5'd5, 32'd31, w);
      checks++; if (w !== 0) begin failures++; $display("FAIL b2b_wait got=%0d want=0", w); end
      checks++; if (ins !== 32'h00042FC3 || ins_valid !== 1'b1) begin failures++; $display("FAIL sra_word got=%h v=%0b want=00042fc3", ins, ins_valid); end
      @(posedge clk); #1;
      checks++; if (ins_count !== c0 + 16'd2) begin failures++; $display("FAIL b2b_count got=%0d want=%0d", ins_count, c0 + 16'd2); end
      checks++; if (ins_valid !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%0b want=0", ins_valid); end
   endtask

   task automatic test_encodings();
      int w;
      ins_ready = 1'b1;
      for (int i = 0; i < NV; i++) begin
         issue(V_K[i], V_RS[i], V_RT[i], V_RD[i], V_IMM[i], w);
         checks++;
         if (ins !== V_EXP[i] || ins_valid !== 1'b1) begin
            failures++;
            $display("FAIL enc_%0d got=%h v=%0b want=%h", i, ins, ins_valid, V_EXP[i]);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_li_stall();
      int w;
      ins_ready = 1'b0;
      issue(5'd21, 5'd0, 5'd8, 5'd0, 32'h12345678, w);
      for (int i = 0; i < 3; i++) begin
         checks++; if (ins !== 32'h3C081234 || ins_valid !== 1'b1) begin failures++; $display("FAIL li_w1_%0d got=%h v=%0b want=3c081234", i, ins, ins_valid); end
         checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL li_stall_ready_%0d got=%0b want=0", i, req_ready); end
         @(posedge clk); #1;
      end
      ins_ready = 1'b1;
      #1;
      checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL li_two_ready got=%0b want=0", req_ready); end
      @(posedge clk); #1;
      checks++; if (ins !== 32'h35085678 || ins_valid !== 1'b1) begin failures++; $display("FAIL li_w2 got=%h v=%0b want=35085678", ins, ins_valid); end
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL li_done_ready got=%0b want=1", req_ready); end
      @(posedge clk); #1;
      checks++; if (ins_valid !== 1'b0) begin failures++; $display("FAIL li_idle got=%0b want=0", ins_valid); end
   endtask

   task automatic test_li_single();
      int w;
      ins_ready = 1'b1;
      issue(5'd21, 5'd0, 5'd8, 5'd0, 32'h00005678, w);
      checks++; if (ins !== 32'h34085678) begin failures++; $display("FAIL li_lo got=%h want=34085678", ins); end
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL li_lo_ready got=%0b want=1", req_ready); end
      issue(5'd21, 5'd0, 5'd8, 5'd0, 32'h12340000, w);
      checks++; if (ins !== 32'h3C081234) begin failures++; $display("FAIL li_hi got=%h want=3c081234", ins); end
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL li_hi_ready got=%0b want=1", req_ready); end
      @(posedge clk); #1;
      checks++; if (ins_valid !== 1'b0) begin failures++; $display("FAIL li_single_idle got=%0b want=0", ins_valid); end
   endtask

   task automatic test_illegal();
      int w;
      logic [15:0] c0;
      logic [7:0]  e0;
      logic [4:0]  k [4];
      logic [31:0] im [4];
      k = '{5'd10, 5'd12, 5'd6, 5'd25};
      im = '{32'h00008000, 32'h00010000, 32'd32, 32'h0};
      c0 = ins_count;
      e0 = err_count;
      ins_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         issue(k[i], 5'd1, 5'd2, 5'd3, im[i], w);
         checks++; if (err !== 1'b1) begin failures++; $display("FAIL ill_err_%0d got=%0b want=1", i, err); end
         checks++; if (ins_valid !== 1'b0) begin failures++; $display("FAIL ill_valid_%0d got=%0b want=0", i, ins_valid); end
      end
      checks++; if (err_count !== e0 + 8'd4) begin failures++; $display("FAIL ill_count got=%0d want=%0d", err_count, e0 + 8'd4); end
      checks++; if (ins_count !== c0) begin failures++; $display("FAIL ill_ins_count got=%0d want=%0d", ins_count, c0); end
      @(posedge clk); #1;
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL ill_err_clear got=%0b want=0", err); end
      issue(5'd19, 5'd0, 5'd0, 5'd0, 32'h04000000, w);
      checks++; if (err !== 1'b1 || ins_valid !== 1'b0) begin failures++; $display("FAIL ill_j err=%0b v=%0b want=1,0", err, ins_valid); end
      issue(5'd14, 5'd0, 5'd0, 5'd0, 32'hFFFF7FFF, w);
      checks++; if (err !== 1'b1 || ins_valid !== 1'b0) begin failures++; $display("FAIL ill_lw err=%0b v=%0b want=1,0", err, ins_valid); end
      for (int i = 0; i < 260; i++) begin
         issue(5'd31, 5'd0, 5'd0, 5'd0, 32'h0, w);
      end
      checks++; if (err_count !== 8'd255) begin failures++; $display("FAIL ill_saturate got=%0d want=255", err_count); end
      checks++; if (ins_count !== c0) begin failures++; $display("FAIL ill_sat_ins_count got=%0d want=%0d", ins_count, c0); end
   endtask

   task automatic test_rst_mid();
      int w;
      ins_ready = 1'b0;
      issue(5'd21, 5'd0, 5'd8, 5'd0, 32'h12345678, w);
      checks++; if (ins_valid !== 1'b1) begin failures++; $display("FAIL rmid_pre got=%0b want=1", ins_valid); end
      #2;
      rst = 1'b1;
      #1;
      checks++; if (ins_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%0b want=0", ins_valid); end
      checks++; if (dut.pend_valid !== 1'b0) begin failures++; $display("FAIL rmid_pend got=%0b want=0", dut.pend_valid); end
      checks++; if (ins !== 32'h0 || err_count !== 8'h0) begin failures++; $display("FAIL rmid_regs ins=%h ec=%0d want=0,0", ins, err_count); end
      checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL rmid_ready got=%0b want=0", req_ready); end
      @(posedge clk); #1;
      rst = 1'b0;
      ins_ready = 1'b1;
      #1;
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rmid_one got=%0b want=1", req_ready); end
      issue(5'd0, 5'd3, 5'd4, 5'd5, 32'h12345678, w);
      checks++; if (ins !== 32'h0 || ins_valid !== 1'b1) begin failures++; $display("FAIL rmid_nop got=%h v=%0b want=0,1", ins, ins_valid); end
      @(posedge clk); #1;
      checks++; if (ins_count !== 16'd1) begin failures++; $display("FAIL rmid_count got=%0d want=1", ins_count); end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_encodings();
      test_li_stall();
      test_li_single();
      test_illegal();
      test_rst_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mips_insn_encoder.md
# mips_insn_encoder

Streaming MIPS-I instruction encoder: accepts symbolic instruction requests (kind, register fields, immediate) over a valid/ready handshake and emits 32-bit machine words over a second valid/ready handshake. It is the encode-side counterpart of the single-cycle control unit's op/func decode, feeding instruction memory loaders and self-test program generators. The `LI` pseudo-instruction expands to one or two words, and out-of-range immediates are rejected and counted.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid && req_ready`.
- `req_kind` in 5: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SLL, 7 SRL, 8 SRA, 9 JR, 10 ADDI, 11 ANDI, 12 ORI, 13 XORI, 14 LW, 15 SW, 16 BEQ, 17 BNE, 18 LUI, 19 J, 20 JAL, 21 LI; 22-31 illegal.
- `req_rs`, `req_rt`, `req_rd` in 5 each: register numbers.
- `req_imm` in 32: shamt, immediate, branch word offset, or jump word index.
- `ins_valid` out 1: `ins` holds a word.
- `ins_ready` in 1: word consumed when `ins_valid && ins_ready`.
- `ins` out 32: encoded instruction.
- `err` out 1: one-cycle pulse for each rejected request.
- `err_count` out 8: rejected requests, saturating at 255.
- `ins_count` out 16: words consumed downstream, wraps modulo 2^16.

## Operation
- R-type word is {000000, rs, rt, rd, shamt, funct}.
  - funct codes: ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, SLL 000000, SRL 000010, SRA 000011, JR 001000.
  - ALU ops: shamt = 0.
  - Shifts: rs = 0, shamt = imm[4:0]; illegal if imm[31:5] != 0.
  - JR: rt = rd = shamt = 0.
- I-type word is {op, rs, rt, imm[15:0]}.
  - op codes: ADDI 001000, ANDI 001100, ORI 001101, XORI 001110, LW 100011, SW 101011, BEQ 000100, BNE 000101, LUI 001111.
  - Sign-extended kinds (ADDI, LW, SW, BEQ, BNE): illegal unless imm[31:15] is all 0s or all 1s.
  - Zero-extended kinds (ANDI, ORI, XORI, LUI): illegal unless imm[31:16] = 0.
  - LUI forces rs = 0.
- J-type word is {op, imm[25:0]}: J 000010, JAL 000011; illegal unless imm[31:26] = 0.
- NOP emits 32'h00000000.
- LI with rt and 32-bit value V:
  - Word 1: LUI rt, V[31:16].
  - Word 2: ORI rt, rt, V[15:0].
  - If V[31:16] = 0, emit only ORI rt, $0, V[15:0].
  - Else if V[15:0] = 0, emit only the LUI.
  - LI is never illegal.
- Illegal request (kind 22-31 or range failure):
  - Consumed normally (`req_ready` behaves as for a legal request).
  - No word is emitted.
  - `err` pulses the following cycle and `err_count` increments (saturating).
- Datapath: output register (`ins`, `ins_valid`) plus one pending-word register (`pend`, `pend_valid`) used only by two-word LI.
- FSM:
  - ONE: no pending word.
  - TWO: second LI word held in `pend`.
  - ONE -> TWO when a two-word LI is accepted.
  - TWO -> ONE when word 1 is consumed; `pend` moves into the output register in that same edge.

## Timing
- `req_ready` = ONE && (!`ins_valid` || `ins_ready`), combinational. Single-word streams sustain one word per cycle.
- Latency: a word accepted at edge N appears with `ins_valid` = 1 after edge N.
- While `ins_valid && !ins_ready`: `ins` holds stable and `req_ready` = 0.
- Two-word LI: `req_ready` stays 0 until word 2 is loaded. Word 2 follows word 1 with no bubble when `ins_ready` = 1.
- `ins_count` increments on each edge where `ins_valid && ins_ready`.
- `rst` asserted at any time, including mid-LI or mid-stall, immediately forces:
  - FSM = ONE, `ins_valid` = 0, `pend_valid` = 0.
  - `ins` = 0, `err` = 0, `err_count` = 0, `ins_count` = 0.
  - The interrupted LI is dropped.
- `req_ready` = 0 while `rst` is high.

## Test plan
- ADD rs=1 rt=2 rd=3, then SRA rt=4 rd=5 imm=31, `ins_ready` = 1 -> `ins` = 0x00221820 then 0x00042FC3 on consecutive cycles; `ins_count` = 2.
- ADDI rs=1 rt=2 imm=0xFFFFFFFC; J imm=0x00100000; JAL imm=0x00100000 -> 0x2022FFFC, 0x08100000, 0x0C100000.
- LI rt=8 imm=0x12345678 with `ins_ready` low for 3 cycles -> `ins` = 0x3C081234 held stable and `req_ready` = 0 throughout; after release, next word is 0x35085678.
- LI rt=8 imm=0x00005678 -> single word 0x34085678. LI rt=8 imm=0x12340000 -> single word 0x3C081234.
- ADDI imm=0x00008000, ORI imm=0x00010000, SLL imm=32, kind=25 -> four `err` pulses, `err_count` = 4, no words emitted, `ins_count` unchanged.
- `rst` pulsed while LI word 1 is stalled -> `ins_valid` = 0 and `pend_valid` = 0 immediately; a following NOP emits 0x00000000.
